// File: rtl/cache_axi_line_master_if.sv
// AXI4-Lite channel bundle used by the cache line master.
//   master modport : drives AW/W/AR payload+valid, B/R ready
//   slave  modport : drives AW/W/AR ready, B/R response+valid
interface cache_axi_line_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cache_axi_line_master.sv
// AXI4-Lite master port of the direct-mapped cache.
// Converts a line write-back (evict_to_ram) into BLOCK_WIDTH single-beat
// writes and a line fetch (refill_req) into BLOCK_WIDTH single-beat reads,
// ascending from the line base address.
//   clk, rst_n     : clock, asynchronous active-low reset
//   evict_to_ram   : request level, write back evict_line (wins over refill)
//   refill_req     : request level, fetch line at line_addr
//   line_addr      : line base byte address (offset bits ignored)
//   evict_line     : dirty line, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   evicted        : one-cycle pulse, write-back complete
//   refilled       : one-cycle pulse, refill_line valid
//   refill_line    : fetched line, same packing as evict_line
//   mem_err        : with a pulse, some beat returned a non-OKAY response
//   busy           : high whenever not idle
//   m_axi          : AXI4-Lite master channels
module cache_axi_line_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              evict_to_ram,
  input  logic                              refill_req,
  input  logic [ADDR_WIDTH-1:0]             line_addr,
  input  logic [BLOCK_WIDTH*DATA_WIDTH-1:0] evict_line,
  output logic                              evicted,
  output logic                              refilled,
  output logic [BLOCK_WIDTH*DATA_WIDTH-1:0] refill_line,
  output logic                              mem_err,
  output logic                              busy,
  cache_axi_line_master_if.master           m_axi
);

  localparam int LINE_W   = BLOCK_WIDTH * DATA_WIDTH;
  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BLOCK_WIDTH * BYTES);
  localparam int BEAT_W   = (BLOCK_WIDTH > 1) ? $clog2(BLOCK_WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   refill_q, refill_d;
  logic                err_q, err_d;
  logic                op_evict_q, op_evict_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] wdata_sel;

  assign beat_addr = base_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BYTES);

  always_comb begin
    wdata_sel = '0;
    for (int unsigned k = 0; k < BLOCK_WIDTH; k++) begin
      if (beat_q == BEAT_W'(k)) wdata_sel = line_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // All outputs decode registered state only, so no valid depends on ready.
  assign m_axi.awaddr  = beat_addr;
  assign m_axi.awprot  = '0;
  assign m_axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axi.wdata   = wdata_sel;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axi.bready  = (state_q == WR_RESP);
  assign m_axi.araddr  = beat_addr;
  assign m_axi.arprot  = '0;
  assign m_axi.arvalid = (state_q == RD_REQ);
  assign m_axi.rready  = (state_q == RD_RESP);

  assign evicted     = (state_q == DONE) && op_evict_q;
  assign refilled    = (state_q == DONE) && !op_evict_q;
  assign mem_err     = (state_q == DONE) && err_q;
  assign busy        = (state_q != IDLE);
  assign refill_line = refill_q;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    line_d     = line_q;
    refill_d   = refill_q;
    err_d      = err_q;
    op_evict_d = op_evict_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;

    unique case (state_q)
      IDLE: begin
        if (evict_to_ram) begin
          base_d     = line_addr & ~OFF_MASK;
          line_d     = evict_line;
          beat_d     = '0;
          err_d      = 1'b0;
          op_evict_d = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = WR_REQ;
        end else if (refill_req) begin
          base_d     = line_addr & ~OFF_MASK;
          beat_d     = '0;
          err_d      = 1'b0;
          op_evict_d = 1'b0;
          state_d    = RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave once both have.
        if (m_axi.awvalid && m_axi.awready) aw_done_d = 1'b1;
        if (m_axi.wvalid && m_axi.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)          state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != 2'b00) err_d = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d    = beat_q + BEAT_W'(1);
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (m_axi.arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (m_axi.rvalid) begin
          for (int unsigned k = 0; k < BLOCK_WIDTH; k++) begin
            if (beat_q == BEAT_W'(k)) refill_d[k*DATA_WIDTH +: DATA_WIDTH] = m_axi.rdata;
          end
          if (m_axi.rresp != 2'b00) err_d = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      line_q     <= '0;
      refill_q   <= '0;
      err_q      <= 1'b0;
      op_evict_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      line_q     <= line_d;
      refill_q   <= refill_d;
      err_q      <= err_d;
      op_evict_q <= op_evict_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: doc/cache_axi_line_master.md
Name: cache_axi_line_master

Overview:
- AXI4-Lite master port of the direct-mapped cache; sits directly downstream of the cache controller FSM.
- Turns the controller's evict request into BLOCK_WIDTH single-beat AXI4-Lite writes (write-back of a dirty line).
- Turns its refill request into BLOCK_WIDTH single-beat reads.
- Returns one-cycle evicted/refilled completion pulses, plus the refilled line and a response-error flag.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, AXI data width and cache word width (multiple of 8)
BLOCK_WIDTH, 4, words per cache line (power of 2, >=1)

Ports:
clk  in  1  system clock; everything on rising edge
rst_n  in  1  asynchronous active-low reset
evict_to_ram  in  1  level; controller requests write-back of evict_line
refill_req  in  1  level; controller requests line fetch
line_addr  in  ADDR_WIDTH  line base byte address
evict_line  in  BLOCK_WIDTH*DATA_WIDTH  dirty line; word k at [k*DATA_WIDTH +: DATA_WIDTH]
evicted  out  1  one-cycle pulse: write-back complete
refilled  out  1  one-cycle pulse: refill complete, refill_line valid
refill_line  out  BLOCK_WIDTH*DATA_WIDTH  fetched line, same packing as evict_line
mem_err  out  1  valid with evicted/refilled: some beat returned non-OKAY
busy  out  1  high whenever state != IDLE
m_axi_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1;  m_axi_awready  in  1
m_axi_wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1;  m_axi_wready  in  1
m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
m_axi_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1;  m_axi_arready  in  1
m_axi_rdata  in  DATA_WIDTH;  m_axi_rresp  in  2;  m_axi_rvalid  in  1;  m_axi_rready  out  1

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; beat counter is 0.
  - All valid/ready outputs, evicted, refilled, mem_err and busy are 0; refill_line is 0.
  - Reset mid-transaction abandons it immediately; no completion pulse is produced.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - evict_to_ram=1 -> latch line_addr (low log2(BLOCK_WIDTH*DATA_WIDTH/8) bits forced 0) and evict_line; beat=0; clear err; go to WR_REQ.
  - Else refill_req=1 -> latch address the same way; beat=0; clear err; go to RD_REQ.
  - Both asserted -> evict wins.
- Beat address = base + beat*(DATA_WIDTH/8). Beats run in ascending order. awprot=arprot=3'b000. wstrb is all ones.
- WR_REQ:
  - awvalid and wvalid both rise on entry.
  - Each drops only in the cycle after its own handshake (valid&ready). The two handshakes may complete in either order or in the same cycle.
  - awaddr and wdata stay stable while their valid is high.
  - Once both handshakes are done -> WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: bresp!=2'b00 sets err (sticky).
  - If beat==BLOCK_WIDTH-1 -> DONE; else beat++ and return to WR_REQ.
- RD_REQ: arvalid=1 until arready, then -> RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: capture rdata into refill_line word beat; rresp!=OKAY sets err.
  - If last beat -> DONE; else beat++ and return to RD_REQ.
- One transaction outstanding at a time. Minimum per beat is 2 cycles with ready tied high. Line latency is 2*BLOCK_WIDTH+1 cycles from request to pulse.
- DONE (one cycle):
  - Pulse evicted or refilled, matching the operation; mem_err=err during the pulse.
  - Then unconditionally go to IDLE.
  - The controller must drop its request level by the cycle after the pulse. A request still high in IDLE starts a new operation.
- Requests, line_addr and evict_line are ignored outside IDLE. Inputs are sampled only at acceptance.
- refill_line holds its value until the next refill's first R capture. Eviction never modifies it.
- Misaligned line_addr low bits are silently zeroed.
- AXI compliance:
  - No valid depends on the corresponding ready.
  - A valid never deasserts before its handshake.
  - B or R arriving while the matching ready is low is held by the slave; nothing is lost.

Test Plan:
- Evict, zero-wait slave: BLOCK_WIDTH=4, line_addr=0x1004, evict_line words {0xA0,0xA1,0xA2,0xA3} -> AW addresses 0x1000,0x1004,0x1008,0x100C in order with matching wdata, wstrb=0xF; evicted pulses once at cycle 9 after acceptance; mem_err=0.
- Refill with random AR/R backpressure (0-5 stall cycles): memory at 0x2000..0x200C = 0x11..0x44 -> refill_line={0x44,0x33,0x22,0x11} (word0 at LSB); single refilled pulse; no valid drops before ready.
- AW/W skew: awready delayed 3 cycles while wready=1 immediately, then swapped on next beat -> wvalid/awvalid drop independently; exactly one B waited per beat; data correct.
- Error: bresp=2'b10 on beat 2 of an evict -> all 4 beats still issued; evicted with mem_err=1; following refill with all OKAY gives mem_err=0.
- Simultaneous evict_to_ram and refill_req in IDLE -> write-back runs first; after evicted, refill starts only if refill_req is still high in IDLE.
- rst_n low mid-RD_RESP (beat 1) -> arvalid/rready/busy are 0 asynchronously; no refilled pulse; a fresh refill after release starts at beat 0 with address base+0.
